little_boss_fetch_arb: RTL and testbench

Round-robin read scheduler for the single-port little-boss sprite RAM (41x41 pixels, 24-bit RGB, 1681 words). It shares the RAM between up to N_REQ draw units, such as per-lane boss renderers, plus one priority write/loader port. It converts sprite-local (x,y) into a linear RAM address, covers the RAM's one-cycle read latency, and returns tagged pixel data with a transparency flag to the color mapper.

---
 rtl/little_boss_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/little_boss_fetch_arb.sv | 127 ++++++++++++
 tb/tb_little_boss_fetch_arb.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/little_boss_pkg.sv
// rtl/little_boss_pkg.sv - shared constants and types for the little-boss sprite RAM path
// Contents: sprite geometry, RAM address/color widths, transparent key color,
//           pixel_t (24-bit RGB) and coord_t (6-bit sprite coordinate).
package little_boss_pkg;

  localparam int SPR_W     = 41;
  localparam int SPR_H     = 41;
  localparam int SPR_DEPTH = SPR_W * SPR_H;
  localparam int ADDR_W    = 19;
  localparam int COLOR_W   = 24;

  localparam logic [COLOR_W-1:0] KEY_COLOR = 24'hFF00FF;

  typedef logic [COLOR_W-1:0] pixel_t;
  typedef logic [5:0]         coord_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant selector
// Ports: req     - request vector
//        en      - when low no grant is issued
//        ptr     - index with highest priority this cycle
//        gnt     - one-hot grant
//        gnt_idx - index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  // Scan from ptr upward, wrapping at N, and take the first request seen.
  always_comb begin
    int   j;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (en && !found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/little_boss_fetch_arb.sv
// rtl/little_boss_fetch_arb.sv - round-robin read scheduler for the little-boss sprite RAM
// Ports: Clk, Reset_n (async, active-low)
//        req_valid/req_x/req_y/req_ready - per-requester read handshake (grant = ready)
//        wr_valid/wr_addr/wr_data        - loader write port, priority over reads
//        ram_*                           - combinational drive of the external RAM
//        ram_data_Out                    - RAM read data, one cycle after its address
//        rsp_valid/rsp_id/rsp_data/rsp_opaque - registered response, two cycles after grant
module little_boss_fetch_arb #(
  parameter int          N_REQ     = 4,
  parameter int          SPR_W     = little_boss_pkg::SPR_W,
  parameter int          SPR_H     = little_boss_pkg::SPR_H,
  parameter logic [23:0] KEY_COLOR = little_boss_pkg::KEY_COLOR,
  parameter int          ID_W      = $clog2(N_REQ)
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*6-1:0]   req_x,
  input  logic [N_REQ*6-1:0]   req_y,
  output logic [N_REQ-1:0]     req_ready,
  input  logic                 wr_valid,
  input  logic [10:0]          wr_addr,
  input  logic [23:0]          wr_data,
  output logic                 ram_we,
  output logic [18:0]          ram_write_address,
  output logic [23:0]          ram_data_In,
  output logic [18:0]          ram_read_address,
  input  logic [23:0]          ram_data_Out,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [23:0]          rsp_data,
  output logic                 rsp_opaque
);

  import little_boss_pkg::*;

  localparam int DEPTH = SPR_W * SPR_H;

  logic            wr_ok;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_any;
  logic [ID_W-1:0] ptr;
  coord_t          sel_x;
  coord_t          sel_y;
  logic            in_range;
  logic [10:0]     rd_lin;

  logic            s1_valid;
  logic [ID_W-1:0] s1_id;
  logic            s1_in_range;

  // Loader writes beyond the sprite are ignored entirely so reads keep flowing.
  assign wr_ok             = wr_valid && (wr_addr < 11'(DEPTH));
  assign ram_we            = wr_ok;
  assign ram_write_address = ADDR_W'(wr_addr);
  assign ram_data_In       = wr_data;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_rr_arbiter (
    .req     (req_valid),
    .en      (!wr_ok),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign gnt_any   = |gnt;

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_x = req_x[i*6 +: 6];
        sel_y = req_y[i*6 +: 6];
      end
    end
  end

  assign in_range = (sel_x < coord_t'(SPR_W)) && (sel_y < coord_t'(SPR_H));
  assign rd_lin   = 11'(sel_y) * 11'(SPR_W) + 11'(sel_x);

  // Out-of-range reads still occupy a slot; they park the RAM at address 0
  // and the response is forced to transparent black downstream.
  assign ram_read_address = (gnt_any && in_range) ? ADDR_W'(rd_lin) : '0;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Stage 1: remember what was granted while the RAM performs the read.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid    <= 1'b0;
      s1_id       <= '0;
      s1_in_range <= 1'b0;
    end else begin
      s1_valid    <= gnt_any;
      s1_id       <= gnt_idx;
      s1_in_range <= in_range;
    end
  end

  // Stage 2: capture RAM data, mask out-of-range, classify transparency.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_opaque <= 1'b0;
    end else begin
      rsp_valid  <= s1_valid;
      rsp_id     <= s1_id;
      rsp_data   <= (s1_valid && s1_in_range) ? pixel_t'(ram_data_Out) : '0;
      rsp_opaque <= s1_valid && s1_in_range && (ram_data_Out != KEY_COLOR);
    end
  end

endmodule

// File: tb/tb_little_boss_fetch_arb.sv
// tb/tb_little_boss_fetch_arb.sv - scoreboard bench for little_boss_fetch_arb with a RAM model
module tb_little_boss_fetch_arb;

  localparam logic [23:0] KEY = 24'hFF00FF;

  typedef struct {
    int          id;
    logic [23:0] data;
    logic        opq;
    int          due;
  } exp_t;

  logic        Clk;
  logic        Reset_n;
  logic [3:0]  req_valid;
  logic [23:0] req_x;
  logic [23:0] req_y;
  logic [3:0]  req_ready;
  logic        wr_valid;
  logic [10:0] wr_addr;
  logic [23:0] wr_data;
  logic        ram_we;
  logic [18:0] ram_write_address;
  logic [23:0] ram_data_In;
  logic [18:0] ram_read_address;
  logic [23:0] ram_data_Out;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [23:0] rsp_data;
  logic        rsp_opaque;

  logic [5:0]  rx [4];
  logic [5:0]  ry [4];
  logic [23:0] mem [0:2047];
  logic [23:0] exp_mem [0:2047];
  exp_t        sb [$];
  int          cyc;
  int          m_ptr;
  int          n_checks;
  int          n_fail;

  little_boss_fetch_arb dut (
    .Clk               (Clk),
    .Reset_n           (Reset_n),
    .req_valid         (req_valid),
    .req_x             (req_x),
    .req_y             (req_y),
    .req_ready         (req_ready),
    .wr_valid          (wr_valid),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .ram_we            (ram_we),
    .ram_write_address (ram_write_address),
    .ram_data_In       (ram_data_In),
    .ram_read_address  (ram_read_address),
    .ram_data_Out      (ram_data_Out),
    .rsp_valid         (rsp_valid),
    .rsp_id            (rsp_id),
    .rsp_data          (rsp_data),
    .rsp_opaque        (rsp_opaque)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_x[i*6 +: 6] = rx[i];
      req_y[i*6 +: 6] = ry[i];
    end
  end

  // External single-port sprite RAM: registered read, write committed at the edge.
  always @(posedge Clk) begin
    if (ram_we) mem[ram_write_address[10:0]] <= ram_data_In;
    ram_data_Out <= mem[ram_read_address[10:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive one cycle of requests at the negedge, check the combinational side,
  // push the expected response, then advance to the next negedge.
  task automatic issue(input logic [3:0] v);
    int   e;
    int   a;
    int   j;
    logic wl;
    logic ir;
    exp_t t;
    req_valid = v;
    #1;
    wl = wr_valid && (wr_addr < 11'd1681);
    check("ram_we", ram_we, wl);
    if (wl) begin
      check("ram_write_address", ram_write_address, wr_addr);
      check("ram_data_In", ram_data_In, wr_data);
      exp_mem[wr_addr] = wr_data;
    end
    e = -1;
    if (!wl) begin
      for (int k = 0; k < 4; k++) begin
        j = (m_ptr + k) % 4;
        if (e < 0 && v[j]) e = j;
      end
    end
    check("req_ready", req_ready, (e < 0) ? 32'd0 : (32'd1 << e));
    if (e >= 0) begin
      ir = (rx[e] < 6'd41) && (ry[e] < 6'd41);
      a  = ir ? int'(ry[e]) * 41 + int'(rx[e]) : 0;
      check("ram_read_address", ram_read_address, a);
      t.id   = e;
      t.data = ir ? exp_mem[a] : 24'h0;
      t.opq  = ir && (t.data != KEY);
      t.due  = cyc + 2;
      sb.push_back(t);
      m_ptr = (e + 1) % 4;
    end else begin
      check("ram_read_address_idle", ram_read_address, 0);
    end
    @(negedge Clk);
  endtask

  // Response monitor: every expected entry must appear exactly on its due cycle.
  initial begin
    exp_t t;
    forever begin
      @(negedge Clk);
      #2;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        t = sb.pop_front();
        check("rsp_valid", rsp_valid, 1);
        if (rsp_valid) begin
          check("rsp_id", rsp_id, t.id);
          check("rsp_data", rsp_data, t.data);
          check("rsp_opaque", rsp_opaque, t.opq);
        end
      end else if (rsp_valid) begin
        check("rsp_spurious", rsp_valid, 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    m_ptr     = 0;
    Reset_n   = 1'b0;
    req_valid = '0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    for (int i = 0; i < 4; i++) begin
      rx[i] = '0;
      ry[i] = '0;
    end
    for (int i = 0; i < 2048; i++) begin
      mem[i]     <= 24'(i * 40503 + 66051);
      exp_mem[i]  = 24'(i * 40503 + 66051);
    end
    mem[100]     <= KEY;
    exp_mem[100]  = KEY;

    repeat (3) @(negedge Clk);
    #1;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_opaque", rsp_opaque, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Round robin with all four requesters held valid.
    for (int i = 0; i < 4; i++) begin
      rx[i] = 6'(i * 3);
      ry[i] = 6'(i + 5);
    end
    repeat (8) issue(4'b1111);
    issue(4'b0000);

    // Single requester, (2,1) -> 43.
    rx[0] = 6'd2;
    ry[0] = 6'd1;
    issue(4'b0001);
    repeat (2) issue(4'b0000);

    // Write wins over pending reads; then the new pixel is read back.
    rx[1] = 6'd7;  ry[1] = 6'd3;
    rx[2] = 6'd9;  ry[2] = 6'd9;
    wr_valid = 1'b1;
    wr_addr  = 11'd43;
    wr_data  = 24'h123456;
    issue(4'b0110);
    wr_valid = 1'b0;
    issue(4'b0110);
    issue(4'b0100);
    rx[3] = 6'd2;
    ry[3] = 6'd1;
    issue(4'b1000);

    // Write immediately followed by a read of the same word.
    wr_valid = 1'b1;
    wr_addr  = 11'd50;
    wr_data  = 24'hABCDEF;
    issue(4'b0000);
    wr_valid = 1'b0;
    rx[0] = 6'd9;
    ry[0] = 6'd1;
    issue(4'b0001);

    // Boundaries: last pixel, x and y out of range, key-colored pixel.
    rx[0] = 6'd40; ry[0] = 6'd40;
    issue(4'b0001);
    rx[1] = 6'd41; ry[1] = 6'd0;
    issue(4'b0010);
    rx[2] = 6'd18; ry[2] = 6'd2;
    issue(4'b0100);
    rx[3] = 6'd0;  ry[3] = 6'd41;
    issue(4'b1000);

    // Illegal write address is dropped and the read proceeds.
    wr_valid = 1'b1;
    wr_addr  = 11'd1681;
    wr_data  = 24'hDEADBE;
    rx[0] = 6'd1;
    ry[0] = 6'd0;
    issue(4'b0001);
    wr_valid = 1'b0;
    repeat (2) issue(4'b0000);

    // Reset one cycle after a grant: nothing in flight may reappear.
    rx[2] = 6'd5;
    ry[2] = 6'd5;
    issue(4'b0100);
    Reset_n   = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("rst_mid_rsp_valid", rsp_valid, 0);
    sb.delete();
    m_ptr = 0;
    repeat (2) begin
      @(negedge Clk);
      #1;
      check("rst_hold_rsp_valid", rsp_valid, 0);
    end
    @(negedge Clk);
    req_valid = '0;
    Reset_n   = 1'b1;
    repeat (4) issue(4'b0000);
    issue(4'b1111);
    issue(4'b0000);

    repeat (4) issue(4'b0000);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
